lc3_isdu_fsm: RTL and testbench
===============================

# lc3_isdu_fsm

Instruction sequencing and decode unit for the LC-3 datapath. Moore FSM that steps each instruction through fetch, decode and execute. Drives every register load enable, bus gate, mux select and SRAM strobe, including LD_BEN and LD_CC to the NZP/BEN flag stage. Consumes the registered BEN from that stage to resolve branches.

## Interface
- No parameters.
- Reset and clock: synchronous, active-high reset `Reset`; clock `Clk`.
- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high; forces Halted
- Run  in  1  leave Halted and start fetching
- Continue  in  1  resume from PAUSE
- Opcode  in  4  IR[15:12]
- IR_5  in  1  IR[5], immediate/register select for ADD/AND
- BEN  in  1  registered branch-enable flag
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per state
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = address adder
- DRMUX  out  1  0 = IR[11:9], 1 = R7
- SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6]
- SR2MUX  out  1  0 = register, 1 = sext imm5
- ADDR1MUX  out  1  0 = PC, 1 = SR1
- ADDR2MUX  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
- Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
- LD_MDR rule: when Mem_OE = 1, LD_MDR loads MDR from the bus.

## Operation
- Moore machine. All outputs decode from the current state only.
- Default output values: every enable, gate and select = 0; Mem_OE = Mem_WE = 1.
- Halted: all defaults. Go to S18 when Run = 1, otherwise stay.
- Fetch sequence:
  - S18: GatePC, LD_MAR, LD_PC, PCMUX = 00.
  - S33_1: Mem_OE = 0.
  - S33_2: Mem_OE = 0, LD_MDR.
  - S35: GateMDR, LD_IR.
  - S32: LD_BEN, then dispatch on Opcode.
- Dispatch from S32:
  - 0001 → S01 (ADD)
  - 0101 → S05 (AND)
  - 1001 → S09 (NOT)
  - 0000 → S00 (BR)
  - 1100 → S12 (JMP)
  - 0100 → S04 (JSR)
  - 0110 → S06 (LDR)
  - 0111 → S07 (STR)
  - 1101 → PauseIR1
  - any other opcode → S18 (NOP)
- Arithmetic/logic states. Each asserts SR1MUX = 1, SR2MUX = IR_5, GateALU, LD_REG, LD_CC, DRMUX = 0, then → S18.
  - S01: ALUK = 00.
  - S05: ALUK = 01.
  - S09: ALUK = 10.
- Branch and jump:
  - S00: no outputs. BEN = 1 → S22, else → S18.
  - S22: ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC; → S18.
  - S12: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00, PCMUX = 10, LD_PC; → S18.
  - S04: GatePC, DRMUX = 1, LD_REG; → S21.
  - S21: ADDR1MUX = 0, ADDR2MUX = 11, PCMUX = 10, LD_PC; → S18.
- Load (LDR):
  - S06: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01, GateMARMUX, LD_MAR; → S25_1.
  - S25_1: Mem_OE = 0.
  - S25_2: Mem_OE = 0, LD_MDR.
  - S27: GateMDR, DRMUX = 0, LD_REG, LD_CC; → S18.
- Store (STR):
  - S07: same outputs as S06; → S23.
  - S23: SR1MUX = 0, ALUK = 11, GateALU, LD_MDR.
  - S16_1, S16_2: Mem_WE = 0 in both; → S18.
- PAUSE:
  - PauseIR1: LD_LED. Stay while Continue = 0, then → PauseIR2.
  - PauseIR2: stay while Continue = 1, then → S18.

## Timing
- Reset has priority over every transition. A Reset in any state, including mid memory access, puts the FSM in Halted on the next edge.
- After Reset, outputs go to their defaults with no glitching: Mem_WE = Mem_OE = 1 and LD_* = 0 from the first cycle.
- Fetch is 5 cycles (S18 through S32).
- Total cycles per instruction:
  - ADD, AND, NOT: 6.
  - BR not taken: 6. BR taken: 7.
  - JMP: 6. JSR: 7.
  - LDR, STR: 9.
  - NOP: 5.
- BEN is registered at the end of S32 and sampled in S00 one cycle later. It therefore reflects the CC written by the previous instruction.
- The SRAM sees Mem_OE or Mem_WE held low for exactly 2 consecutive cycles per access. Mem_OE and Mem_WE are never low in the same cycle.
- Run is sampled only in Halted. Continue is sampled only in the pause states.

## Test plan
- Reset in S33_2 with Mem_OE low → next cycle Halted, Mem_OE = 1, all loads 0. Run = 1 → S18 with GatePC = LD_PC = LD_MAR = 1.
- Opcode 0001, IR_5 = 1 → exactly 6 cycles from S18 back to S18. In the execute cycle: SR2MUX = 1, ALUK = 00, GateALU = LD_REG = LD_CC = 1.
- Opcode 0000 twice:
  - BEN = 1 → S22 with PCMUX = 10, ADDR2MUX = 10; 7 cycles total.
  - BEN = 0 → S18 directly after S00; 6 cycles total.
- Opcode 0111 → S23 asserts ALUK = 11, LD_MDR. Exactly 2 cycles follow with Mem_WE = 0 and Mem_OE = 1. Back in S18 at cycle 9.
- Opcode 1101 → LD_LED held for as long as Continue = 0, including 10 idle cycles. Raise Continue → PauseIR2 holds until Continue drops → S18.
- Opcode 1111 → NOP, back in S18 after 5 cycles. Assert on every state: no cycle has more than one Gate* high.

Source files
------------

// File: rtl/lc3_isdu_fsm.sv
// lc3_isdu_fsm: LC-3 instruction sequencer; Moore FSM driving every datapath load, gate, mux select and SRAM strobe.
module lc3_isdu_fsm (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE
);
   typedef enum logic [4:0] {
      halted, s18, s33_1, s33_2, s35, s32,
      s01, s05, s09, s00, s22, s12, s04, s21,
      s06, s25_1, s25_2, s27, s07, s23, s16_1, s16_2,
      pause_ir1, pause_ir2
   } state_t;
   state_t state, next;
   always_ff @(posedge Clk) state <= Reset ? halted : next;
   always_comb begin
      next       = state;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = 2'b00;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      ADDR2MUX   = 2'b00;
      ALUK       = 2'b00;
      Mem_OE     = 1'b1;
      Mem_WE     = 1'b1;
      case (state)
         halted: next = Run ? s18 : halted;
         s18: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            LD_PC  = 1'b1;
            next   = s33_1;
         end
         s33_1: begin
            Mem_OE = 1'b0;
            next   = s33_2;
         end
         s33_2: begin
            Mem_OE = 1'b0;
            LD_MDR = 1'b1;
            next   = s35;
         end
         s35: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
            next    = s32;
         end
         s32: begin
            LD_BEN = 1'b1;
            case (Opcode)
               4'b0001: next = s01;
               4'b0101: next = s05;
               4'b1001: next = s09;
               4'b0000: next = s00;
               4'b1100: next = s12;
               4'b0100: next = s04;
               4'b0110: next = s06;
               4'b0111: next = s07;
               4'b1101: next = pause_ir1;
               default: next = s18;
            endcase
         end
         s01, s05, s09: begin
            SR1MUX  = 1'b1;
            SR2MUX  = IR_5;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            ALUK    = state == s01 ? 2'b00 : state == s05 ? 2'b01 : 2'b10;
            next    = s18;
         end
         s00: next = BEN ? s22 : s18;
         s22: begin
            ADDR2MUX = 2'b10;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
            next     = s18;
         end
         s12: begin
            SR1MUX   = 1'b1;
            ADDR1MUX = 1'b1;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
            next     = s18;
         end
         s04: begin
            GatePC = 1'b1;
            DRMUX  = 1'b1;
            LD_REG = 1'b1;
            next   = s21;
         end
         s21: begin
            ADDR2MUX = 2'b11;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
            next     = s18;
         end
         s06, s07: begin
            SR1MUX     = 1'b1;
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = 2'b01;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            next       = state == s06 ? s25_1 : s23;
         end
         s25_1: begin
            Mem_OE = 1'b0;
            next   = s25_2;
         end
         s25_2: begin
            Mem_OE = 1'b0;
            LD_MDR = 1'b1;
            next   = s27;
         end
         s27: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            next    = s18;
         end
         // Source register for the store data comes from IR[11:9], passed through the ALU
         s23: begin
            ALUK    = 2'b11;
            GateALU = 1'b1;
            LD_MDR  = 1'b1;
            next    = s16_1;
         end
         s16_1: begin
            Mem_WE = 1'b0;
            next   = s16_2;
         end
         s16_2: begin
            Mem_WE = 1'b0;
            next   = s18;
         end
         pause_ir1: begin
            LD_LED = 1'b1;
            next   = Continue ? pause_ir2 : pause_ir1;
         end
         pause_ir2: next = Continue ? pause_ir2 : s18;
         default: next = halted;
      endcase
   end
endmodule

// File: tb/tb_lc3_isdu_fsm.sv
// tb_lc3_isdu_fsm: directed checks of the sequencer's per-state control word and instruction timing.
module tb_lc3_isdu_fsm;
   logic       Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0, IR_5 = 1'b0, BEN = 1'b0;
   logic [3:0] Opcode = 4'b0000;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   int         passed = 0, total = 0;

   lc3_isdu_fsm dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
      .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
      .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   always #5 Clk = ~Clk;

   // Control word: loads(8) gates(4) PCMUX DRMUX SR1MUX SR2MUX ADDR1MUX ADDR2MUX ALUK Mem_OE Mem_WE
   logic [23:0] ctl;
   assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                 GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                 ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

   localparam logic [23:0] IDLE  = 24'b00000000_0000_00_0000_00_00_11;
   localparam logic [23:0] S18   = 24'b10000010_1000_00_0000_00_00_11;
   localparam logic [23:0] RD1   = 24'b00000000_0000_00_0000_00_00_01;
   localparam logic [23:0] RD2   = 24'b01000000_0000_00_0000_00_00_01;
   localparam logic [23:0] S35   = 24'b00100000_0100_00_0000_00_00_11;
   localparam logic [23:0] S32   = 24'b00010000_0000_00_0000_00_00_11;
   localparam logic [23:0] S01I  = 24'b00001100_0010_00_0110_00_00_11;
   localparam logic [23:0] S05R  = 24'b00001100_0010_00_0100_00_01_11;
   localparam logic [23:0] S09I  = 24'b00001100_0010_00_0110_00_10_11;
   localparam logic [23:0] S22   = 24'b00000010_0000_10_0000_10_00_11;
   localparam logic [23:0] S12   = 24'b00000010_0000_10_0101_00_00_11;
   localparam logic [23:0] S04   = 24'b00000100_1000_00_1000_00_00_11;
   localparam logic [23:0] S21   = 24'b00000010_0000_10_0000_11_00_11;
   localparam logic [23:0] S06   = 24'b10000000_0001_00_0101_01_00_11;
   localparam logic [23:0] S27   = 24'b00001100_0100_00_0000_00_00_11;
   localparam logic [23:0] S23   = 24'b01000000_0010_00_0000_00_11_11;
   localparam logic [23:0] WR    = 24'b00000000_0000_00_0000_00_00_10;
   localparam logic [23:0] PAUSE = 24'b00000001_0000_00_0000_00_00_11;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // One clock, then the state's control word plus the bus/strobe exclusivity invariants
   task automatic step(input string tag, input logic [23:0] exp);
      @(posedge Clk);
      #1;
      chk(tag, ctl, exp);
      chk({tag, "_gates"}, {23'd0, $countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1}, 24'd1);
      chk({tag, "_strobes"}, {23'd0, Mem_OE | Mem_WE}, 24'd1);
   endtask

   task automatic fetch();
      step("s33_1", RD1);
      step("s33_2", RD2);
      step("s35", S35);
      step("s32", S32);
   endtask

   initial begin
      step("reset", IDLE);
      Reset = 1'b0;
      step("halted_no_run", IDLE);
      Run = 1'b1;
      step("run_s18", S18);
      Run = 1'b0;
      step("a_s33_1", RD1);
      step("a_s33_2", RD2);
      Reset = 1'b1;
      step("reset_mid_read", IDLE);
      Reset = 1'b0;
      step("halted_again", IDLE);
      Run = 1'b1;
      step("rerun_s18", S18);
      Run = 1'b0;
      Opcode = 4'b0001; IR_5 = 1'b1;
      fetch();
      step("add_exec", S01I);
      step("add_back_s18", S18);
      Opcode = 4'b0101; IR_5 = 1'b0;
      fetch();
      step("and_exec", S05R);
      step("and_back_s18", S18);
      Opcode = 4'b1001; IR_5 = 1'b1;
      fetch();
      step("not_exec", S09I);
      step("not_back_s18", S18);
      Opcode = 4'b0000; BEN = 1'b1;
      fetch();
      step("br_s00", IDLE);
      step("br_taken_s22", S22);
      step("br_taken_s18", S18);
      BEN = 1'b0;
      fetch();
      step("br_s00_nt", IDLE);
      step("br_nt_s18", S18);
      Opcode = 4'b1100;
      fetch();
      step("jmp_s12", S12);
      step("jmp_s18", S18);
      Opcode = 4'b0100;
      fetch();
      step("jsr_s04", S04);
      step("jsr_s21", S21);
      step("jsr_s18", S18);
      Opcode = 4'b0110;
      fetch();
      step("ldr_s06", S06);
      step("ldr_s25_1", RD1);
      step("ldr_s25_2", RD2);
      step("ldr_s27", S27);
      step("ldr_s18", S18);
      Opcode = 4'b0111;
      fetch();
      step("str_s07", S06);
      step("str_s23", S23);
      step("str_s16_1", WR);
      step("str_s16_2", WR);
      step("str_s18", S18);
      Opcode = 4'b1101;
      fetch();
      step("pause1", PAUSE);
      for (int i = 0; i < 10; i++) step("pause1_hold", PAUSE);
      Continue = 1'b1;
      step("pause2", IDLE);
      for (int i = 0; i < 3; i++) step("pause2_hold", IDLE);
      Continue = 1'b0;
      step("pause_s18", S18);
      Opcode = 4'b1111;
      fetch();
      step("nop_s18", S18);
      Opcode = 4'b0111;
      fetch();
      step("str2_s07", S06);
      step("str2_s23", S23);
      step("str2_s16_1", WR);
      Reset = 1'b1;
      step("reset_mid_write", IDLE);
      Reset = 1'b0;
      step("halted_after_write", IDLE);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
